mem_responder: RTL and testbench

- Responder side of the single-outstanding MEM_A/MEM_RE/MEM_WE/MEM_D/MEM_Q/MEM_BUSY/MEM_DONE memory protocol.
- Backs the protocol with an on-chip word array and a programmable fixed latency.
- Lets the vector-add style initiator masters run and be verified against a real target instead of a testbench stub.
- Serves one request at a time and keeps read/write activity counters for bench checking.

---
 rtl/mem_if_pkg.sv | 19 +
 rtl/mem_responder_ram.sv | 24 ++
 rtl/mem_responder.sv | 117 +++++++++++
 tb/tb_mem_responder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared types and defaults for the MEM_A/MEM_RE/MEM_WE/MEM_D/MEM_Q/MEM_BUSY/MEM_DONE
// protocol, used by the responder and by the initiator masters.
package mem_if_pkg;

  localparam int MEM_WA = 32;
  localparam int MEM_WD = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port synchronous word array with registered, enable-gated read data.
module mem_responder_ram #(
  parameter  int WD    = 32,
  parameter  int DEPTH = 4096,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          we,
  input  logic          re,
  input  logic [IW-1:0] idx,
  input  logic [WD-1:0] wd,
  output logic [WD-1:0] rd
);

  logic [WD-1:0] mem [DEPTH];

  // NOTE: the array and its read register carry no reset so they map onto
  // block RAM; contents are undefined until written.
  always_ff @(posedge CLK) begin
    if (we) mem[idx] <= wd;
    if (re) rd <= mem[idx];
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one request, waits a fixed
// latency, commits/returns the word, pulses DONE, and counts completed ops.
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int WA         = MEM_WA,
  parameter int WD         = MEM_WD,
  parameter int DEPTH      = 4096,
  parameter int ADDR_SHIFT = 5,
  parameter int LATENCY    = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [WA-1:0] MEM_A,
  input  logic          MEM_RE,
  input  logic          MEM_WE,
  input  logic [WD-1:0] MEM_D,
  output logic [WD-1:0] MEM_Q,
  output logic          MEM_BUSY,
  output logic          MEM_DONE,
  output logic          ERR,
  output logic [31:0]   RD_CNT,
  output logic [31:0]   WR_CNT
);

  localparam int         IW       = $clog2(DEPTH);
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  state_t        state, state_nxt;
  op_t           op_q;
  logic [IW-1:0] idx_q;
  logic [WD-1:0] d_q;
  logic [7:0]    cnt;
  logic          q_valid;
  logic [WD-1:0] ram_rd;
  logic          accept, finish;
  logic          ram_we, ram_re;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    unique case (state)
      ST_IDLE: if (MEM_RE || MEM_WE) begin
        accept    = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: if (cnt == 8'd0) begin
        finish    = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Array access is gated by the FSM state, so an async reset mid-flight
  // also withdraws the pending write strobe.
  assign ram_we = finish && (op_q == OP_WR);
  assign ram_re = finish && (op_q == OP_RD);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_q    <= OP_RD;
      idx_q   <= '0;
      d_q     <= '0;
      cnt     <= '0;
      ERR     <= 1'b0;
      RD_CNT  <= '0;
      WR_CNT  <= '0;
      q_valid <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= MEM_WE ? OP_WR : OP_RD;
        idx_q <= IW'(MEM_A >> ADDR_SHIFT);
        d_q   <= MEM_D;
        cnt   <= CNT_INIT;
        if (MEM_RE && MEM_WE) ERR <= 1'b1;
      end else if (state == ST_WAIT && cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end
      if (ram_we) WR_CNT <= WR_CNT + 32'd1;
      if (ram_re) begin
        RD_CNT  <= RD_CNT + 32'd1;
        q_valid <= 1'b1;
      end
    end
  end

  mem_responder_ram #(
    .WD    (WD),
    .DEPTH (DEPTH)
  ) u_ram (
    .CLK (CLK),
    .we  (ram_we),
    .re  (ram_re),
    .idx (idx_q),
    .wd  (d_q),
    .rd  (ram_rd)
  );

  // The RAM read register has no reset; q_valid masks it to zero until the
  // first read completes after reset.
  assign MEM_Q    = q_valid ? ram_rd : '0;
  assign MEM_BUSY = (state != ST_IDLE);
  assign MEM_DONE = (state == ST_DONE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances at LATENCY 4, 1 and 255.
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic [31:0] mem_a  [3];
  logic        re     [3];
  logic        we     [3];
  logic [31:0] mem_d  [3];
  logic [31:0] q_o    [3];
  logic        busy   [3];
  logic        done   [3];
  logic        err    [3];
  logic [31:0] rd_cnt [3];
  logic [31:0] wr_cnt [3];

  int checks   = 0;
  int failures = 0;
  int lat_of [3] = '{4, 1, 255};

  mem_responder #(.LATENCY(4)) u0 (
    .CLK(clk), .RST(rst), .MEM_A(mem_a[0]), .MEM_RE(re[0]), .MEM_WE(we[0]),
    .MEM_D(mem_d[0]), .MEM_Q(q_o[0]), .MEM_BUSY(busy[0]), .MEM_DONE(done[0]),
    .ERR(err[0]), .RD_CNT(rd_cnt[0]), .WR_CNT(wr_cnt[0]));

  mem_responder #(.LATENCY(1)) u1 (
    .CLK(clk), .RST(rst), .MEM_A(mem_a[1]), .MEM_RE(re[1]), .MEM_WE(we[1]),
    .MEM_D(mem_d[1]), .MEM_Q(q_o[1]), .MEM_BUSY(busy[1]), .MEM_DONE(done[1]),
    .ERR(err[1]), .RD_CNT(rd_cnt[1]), .WR_CNT(wr_cnt[1]));

  mem_responder #(.LATENCY(255)) u2 (
    .CLK(clk), .RST(rst), .MEM_A(mem_a[2]), .MEM_RE(re[2]), .MEM_WE(we[2]),
    .MEM_D(mem_d[2]), .MEM_Q(q_o[2]), .MEM_BUSY(busy[2]), .MEM_DONE(done[2]),
    .ERR(err[2]), .RD_CNT(rd_cnt[2]), .WR_CNT(wr_cnt[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One protocol transaction; called 1 time unit after a rising edge.
  task automatic op(input int u, input bit wr, input bit rd,
                    input logic [31:0] a, input logic [31:0] d,
                    output logic [31:0] q);
    int n;
    int busy_n;
    bit got;
    mem_a[u] = a;
    mem_d[u] = d;
    we[u]    = wr;
    re[u]    = rd;
    @(posedge clk); #1;
    check("accept_busy", 32'(busy[u]), 32'd1);
    we[u]  = 1'b0;
    re[u]  = 1'b0;
    busy_n = 1;
    got    = 1'b0;
    n      = 0;
    while (!got && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (busy[u]) busy_n++;
      if (done[u]) got = 1'b1;
    end
    q = q_o[u];
    check("done_latency", 32'(n), 32'(lat_of[u]));
    @(posedge clk); #1;
    if (busy[u]) busy_n++;
    check("busy_width", 32'(busy_n), 32'(lat_of[u] + 1));
    check("done_pulse", 32'(done[u]), 32'd0);
  endtask

  initial begin
    logic [31:0] q;
    logic [31:0] qa, qb;
    int n;
    for (int u = 0; u < 3; u++) begin
      mem_a[u] = '0; mem_d[u] = '0; re[u] = 1'b0; we[u] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_done", 32'(done[0]), 32'd0);
    check("rst_q",    q_o[0],       32'd0);
    check("rst_err",  32'(err[0]),  32'd0);
    check("rst_rd",   rd_cnt[0],    32'd0);
    check("rst_wr",   wr_cnt[0],    32'd0);

    // Write then read back
    op(0, 1, 0, 32'h40, 32'hDEADBEEF, q);
    check("w1_wr_cnt", wr_cnt[0], 32'd1);
    check("w1_q_kept", q,         32'd0);
    op(0, 0, 1, 32'h40, 32'h0, q);
    check("r1_q",      q,         32'hDEADBEEF);
    check("r1_rd_cnt", rd_cnt[0], 32'd1);

    // Aliasing: 0x20020 >> 5 = 0x1001, mod 4096 = 1 = 0x20 >> 5
    op(0, 1, 0, 32'h20, 32'h11, q);
    op(0, 0, 1, 32'h20020, 32'h0, q);
    check("alias_q", q, 32'h11);

    // RE and WE together: write wins, ERR sticks
    op(0, 1, 1, 32'h60, 32'h5, q);
    check("coll_err",    32'(err[0]), 32'd1);
    check("coll_rd_cnt", rd_cnt[0],   32'd2);
    check("coll_wr_cnt", wr_cnt[0],   32'd3);
    op(0, 0, 1, 32'h60, 32'h0, q);
    check("coll_q",      q,           32'h5);
    check("coll_err2",   32'(err[0]), 32'd1);

    // Request held through BUSY, data changed after acceptance
    mem_a[0] = 32'hA0; mem_d[0] = 32'h123; we[0] = 1'b1;
    @(posedge clk); #1;
    check("hold_busy", 32'(busy[0]), 32'd1);
    mem_d[0] = 32'h999;
    n = 0;
    while (busy[0] && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    we[0] = 1'b0;
    check("hold_width", 32'(n), 32'd5);
    @(posedge clk); #1;
    check("hold_no_reaccept", 32'(busy[0]), 32'd0);
    check("hold_wr_cnt",      wr_cnt[0],    32'd4);
    op(0, 0, 1, 32'hA0, 32'h0, q);
    check("hold_q", q, 32'h123);

    // Reset two cycles into a write
    op(0, 1, 0, 32'h80, 32'h1, q);
    mem_a[0] = 32'h80; mem_d[0] = 32'h77; we[0] = 1'b1;
    @(posedge clk); #1;
    check("rstmid_busy", 32'(busy[0]), 32'd1);
    we[0] = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rstmid_busy0", 32'(busy[0]), 32'd0);
    check("rstmid_done0", 32'(done[0]), 32'd0);
    check("rstmid_wr",    wr_cnt[0],    32'd0);
    check("rstmid_rd",    rd_cnt[0],    32'd0);
    check("rstmid_err",   32'(err[0]),  32'd0);
    check("rstmid_q",     q_o[0],       32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    op(0, 0, 1, 32'h80, 32'h0, q);
    check("rstmid_readback", q,         32'h1);
    check("rstmid_rd1",      rd_cnt[0], 32'd1);

    // Latency sweep on the LATENCY=1 and LATENCY=255 instances
    op(1, 1, 0, 32'h100, 32'hCAFE0001, q);
    op(1, 0, 1, 32'h100, 32'h0, q);
    check("l1_q", q, 32'hCAFE0001);
    op(2, 1, 0, 32'h100, 32'hCAFE00FF, q);
    op(2, 0, 1, 32'h100, 32'h0, q);
    check("l255_q",      q,         32'hCAFE00FF);
    check("l255_rd_cnt", rd_cnt[2], 32'd1);
    check("l255_wr_cnt", wr_cnt[2], 32'd1);

    // Vector-add initiator, SIZE=32: C[i] = A[i] + B[i]
    for (int i = 0; i < 32; i++) begin
      op(0, 1, 0, 32'h1000 + 32'(i) * 32, 32'h0100_0000 + 32'(i) * 7, q);
      op(0, 1, 0, 32'h2000 + 32'(i) * 32, 32'hFFFF_0000 + 32'(i * i * 3), q);
    end
    for (int i = 0; i < 32; i++) begin
      op(0, 0, 1, 32'h1000 + 32'(i) * 32, 32'h0, qa);
      op(0, 0, 1, 32'h2000 + 32'(i) * 32, 32'h0, qb);
      op(0, 1, 0, 32'h3000 + 32'(i) * 32, qa + qb, q);
    end
    for (int i = 0; i < 32; i++) begin
      op(0, 0, 1, 32'h3000 + 32'(i) * 32, 32'h0, q);
      check("vadd_sum", q, (32'h0100_0000 + 32'(i) * 7) + (32'hFFFF_0000 + 32'(i * i * 3)));
    end
    check("vadd_wr_cnt", wr_cnt[0], 32'd96);
    check("vadd_rd_cnt", rd_cnt[0], 32'd97);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
